// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline forwarding/hazard logic:
// operand-mux select codes, per-stage destination tags and the producer test.
package mips_pkg;

  localparam int REG_W = 5;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_REGFILE = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MEM     = 2'd1;
  localparam logic [SEL_W-1:0] SEL_WB      = 2'd2;
  localparam logic [SEL_W-1:0] SEL_POSTWB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             escribe_reg;
    logic             es_carga;
  } tag_etapa_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             escribe_reg;
  } tag_postwb_t;

  localparam tag_etapa_t TAG_BURBUJA = '0;

  // Register $0 is hard-wired to zero, so it is never a produced value.
  function automatic logic produce(input tag_etapa_t t, input logic [REG_W-1:0] r);
    return t.valid && t.escribe_reg && (t.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/selector_origen.sv
// Per-operand source selection and hazard detection against the EX/MEM/WB tags.
// FORWARDING_EN selects forwarding; otherwise every in-flight producer interlocks.
module selector_origen
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] r_i,
  input  logic             usa_i,
  input  tag_etapa_t       tag_ex_i,
  input  tag_etapa_t       tag_mem_i,
  input  tag_etapa_t       tag_wb_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             hazard_carga_o
);

  logic prod_ex;
  logic prod_mem;
  logic prod_wb;

  assign prod_ex  = usa_i && produce(tag_ex_i, r_i);
  assign prod_mem = usa_i && produce(tag_mem_i, r_i);
  assign prod_wb  = usa_i && produce(tag_wb_i, r_i);

`ifdef FORWARDING_EN
  // Youngest producer wins.
  always_comb begin
    sel_o = SEL_REGFILE;
    if (prod_ex) begin
      sel_o = SEL_MEM;
    end else if (prod_mem) begin
      sel_o = SEL_WB;
    end else if (prod_wb) begin
      sel_o = SEL_POSTWB;
    end
  end

  // Only a load in EX cannot be forwarded in time.
  assign hazard_carga_o = prod_ex && tag_ex_i.es_carga;

  logic unused_carga;
  assign unused_carga = tag_mem_i.es_carga ^ tag_wb_i.es_carga;
`else
  assign sel_o          = SEL_REGFILE;
  assign hazard_carga_o = prod_ex || prod_mem || prod_wb;

  logic unused_carga;
  assign unused_carga = tag_ex_i.es_carga ^ tag_mem_i.es_carga ^ tag_wb_i.es_carga;
`endif

endmodule

// File: rtl/unidad_adelantamiento.sv
// Forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
// Define FORWARDING_EN for operand forwarding; undefined gives a full interlock.
module unidad_adelantamiento #(
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_usa_rs,
  input  logic             id_usa_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_escribe_reg,
  input  logic             id_es_carga,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             ex_valid
);
  import mips_pkg::*;

  // Handshake: none; the pipeline advances every cycle. stall holds PC and
  // IF/ID for this cycle only, and EX then receives a bubble.

  tag_etapa_t       ex_q;
  tag_etapa_t       ex_d;
  tag_etapa_t       mem_q;
  tag_etapa_t       wb_q;
  tag_postwb_t      postwb_q;
  logic [SEL_W-1:0] sel_a_q;
  logic [SEL_W-1:0] sel_a_d;
  logic [SEL_W-1:0] sel_b_q;
  logic [SEL_W-1:0] sel_b_d;

  logic [SEL_W-1:0] sel_rs;
  logic [SEL_W-1:0] sel_rt;
  logic             haz_rs;
  logic             haz_rt;
  logic             entra;

  selector_origen u_sel_rs (
    .r_i            (id_rs),
    .usa_i          (id_usa_rs),
    .tag_ex_i       (ex_q),
    .tag_mem_i      (mem_q),
    .tag_wb_i       (wb_q),
    .sel_o          (sel_rs),
    .hazard_carga_o (haz_rs)
  );

  selector_origen u_sel_rt (
    .r_i            (id_rt),
    .usa_i          (id_usa_rt),
    .tag_ex_i       (ex_q),
    .tag_mem_i      (mem_q),
    .tag_wb_i       (wb_q),
    .sel_o          (sel_rt),
    .hazard_carga_o (haz_rt)
  );

  // A flush squashes the ID instruction, so it can never also be held.
  assign stall = id_valid && !flush && (haz_rs || haz_rt);
  assign entra = id_valid && !stall && !flush;

  always_comb begin
    ex_d    = TAG_BURBUJA;
    sel_a_d = SEL_REGFILE;
    sel_b_d = SEL_REGFILE;
    if (entra) begin
      ex_d.valid       = 1'b1;
      ex_d.rd          = id_rd;
      ex_d.escribe_reg = id_escribe_reg;
      ex_d.es_carga    = id_es_carga;
      sel_a_d          = sel_rs;
      sel_b_d          = sel_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= TAG_BURBUJA;
      mem_q    <= TAG_BURBUJA;
      wb_q     <= TAG_BURBUJA;
      postwb_q <= '0;
      sel_a_q  <= SEL_REGFILE;
      sel_b_q  <= SEL_REGFILE;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      postwb_q <= {wb_q.valid, wb_q.rd, wb_q.escribe_reg};
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  // The post-WB tag is the last stop before a tag retires; it feeds no select.
  logic unused_postwb;
  assign unused_postwb = ^postwb_q;

  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign ex_valid = ex_q.valid;

endmodule
